// File: rtl/run_ctrl_pkg.sv
// Shared types and default widths for the PC-stage run-control sequencer.
package run_ctrl_pkg;

  localparam int PC_W_DEF  = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/run_ctrl_if.sv
// Launch/decode inputs and PC-stage control outputs of run_ctrl; master drives launch and decode.
interface run_ctrl_if #(
  parameter int PC_W  = run_ctrl_pkg::PC_W_DEF,
  parameter int CNT_W = run_ctrl_pkg::CNT_W_DEF
);

  logic             Req;
  logic [PC_W-1:0]  ReqAddr;
  logic             DecHalt;
  logic             DecBranch;
  logic             DecBranchCond;
  logic             CondFlag;
  logic [PC_W-1:0]  DecOffset;
  logic             StallReq;

  logic             Start;
  logic             Halt;
  logic             Branch;
  logic             BranchCond;
  logic [PC_W-1:0]  Offset;
  logic [PC_W-1:0]  Start_Addr;
  logic             Running;
  logic             Done;
  logic [CNT_W-1:0] InstCount;
  logic             Timeout;

  modport master (
    output Req, ReqAddr, DecHalt, DecBranch, DecBranchCond, CondFlag, DecOffset, StallReq,
    input  Start, Halt, Branch, BranchCond, Offset, Start_Addr, Running, Done, InstCount, Timeout
  );

  modport slave (
    input  Req, ReqAddr, DecHalt, DecBranch, DecBranchCond, CondFlag, DecOffset, StallReq,
    output Start, Halt, Branch, BranchCond, Offset, Start_Addr, Running, Done, InstCount, Timeout
  );

endinterface

// File: rtl/run_ctrl.sv
// Run-control sequencer: launch, PC load pulse, stall-gated branch/halt, retire count.
// Optional RUN_WATCHDOG_EN adds a RUN-cycle watchdog that forces HALTED and sets Timeout.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int          PC_W       = PC_W_DEF,
  parameter int          CNT_W      = CNT_W_DEF,
  parameter logic [15:0] MAX_CYCLES = 16'd4096
) (
  input logic       CLK,
  input logic       Reset,
  run_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   start_addr_q, start_addr_d;
  logic [CNT_W-1:0]  icnt_q, icnt_d;
  logic              done_q, done_d;
  logic              accept;
  logic              wd_fire;

  logic              start_c, halt_c, branch_c, bcond_c, running_c;
  logic [PC_W-1:0]   offset_c;

`ifdef RUN_WATCHDOG_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;

  // Fires on the RUN cycle that is number MAX_CYCLES since LOAD, stalled cycles included.
  assign wd_fire = (state_q == RUN) && (wd_cnt_q == (MAX_CYCLES - 16'd1));

  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    if (state_q == LOAD)     wd_cnt_d = 16'd0;
    else if (state_q == RUN) wd_cnt_d = wd_cnt_q + 16'd1;
    if (wd_fire)     timeout_d = 1'b1;
    else if (accept) timeout_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wd_cnt_q  <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.Timeout = timeout_q;
`else
  assign wd_fire     = 1'b0;
  assign bus.Timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    start_addr_d = start_addr_q;
    icnt_d       = icnt_q;
    done_d       = 1'b0;
    accept       = 1'b0;
    start_c      = 1'b0;
    halt_c       = 1'b1;
    branch_c     = 1'b0;
    bcond_c      = 1'b0;
    offset_c     = '0;
    running_c    = 1'b0;

    case (state_q)
      IDLE, HALTED: begin
        if (bus.Req) begin
          accept       = 1'b1;
          start_addr_d = bus.ReqAddr;
          icnt_d       = '0;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        start_c   = 1'b1;
        halt_c    = 1'b0;
        running_c = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        running_c = 1'b1;
        if (wd_fire || (!bus.StallReq && bus.DecHalt)) begin
          state_d = HALTED;
          done_d  = 1'b1;
        end else if (!bus.StallReq) begin
          halt_c   = 1'b0;
          branch_c = bus.DecBranch;
          // Both flags set collapses to one unconditional branch.
          bcond_c  = bus.DecBranchCond & bus.CondFlag & ~bus.DecBranch;
          offset_c = (branch_c | bcond_c) ? bus.DecOffset : '0;
          icnt_d   = (&icnt_q) ? icnt_q : icnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (Reset) begin
      start_c   = 1'b0;
      halt_c    = 1'b1;
      branch_c  = 1'b0;
      bcond_c   = 1'b0;
      offset_c  = '0;
      running_c = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= IDLE;
      start_addr_q <= '0;
      icnt_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_addr_q <= start_addr_d;
      icnt_q       <= icnt_d;
      done_q       <= done_d;
    end
  end

  assign bus.Start      = start_c;
  assign bus.Halt       = halt_c;
  assign bus.Branch     = branch_c;
  assign bus.BranchCond = bcond_c;
  assign bus.Offset     = offset_c;
  assign bus.Running    = running_c;
  assign bus.Start_Addr = start_addr_q;
  assign bus.Done       = done_q;
  assign bus.InstCount  = icnt_q;

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
Run-control sequencer for the instruction-fetch PC stage. It owns the PC-stage control inputs: Start, Halt, Branch, BranchCond, Offset and Start_Addr. It accepts a program-launch request, pulses the PC load, and gates decoder branch/halt controls with stall requests. It also counts retired instructions and reports completion to the testbench/top level.

Parameters:
PC_W, 8, PC / start-address / offset width
CNT_W, 16, retired-instruction counter width
MAX_CYCLES, 16'd4096, watchdog limit in RUN cycles (used only with RUN_WATCHDOG_EN)

Ports:
CLK  in  1  system clock, all state updates on posedge
Reset  in  1  synchronous, active-high reset
Req  in  1  launch request, one-cycle pulse or level, sampled in IDLE/HALTED only
ReqAddr  in  PC_W  program start address, captured when Req accepted
DecHalt  in  1  current instruction is halt
DecBranch  in  1  current instruction is unconditional branch
DecBranchCond  in  1  current instruction is conditional branch
CondFlag  in  1  branch condition result for current instruction
DecOffset  in  PC_W  signed branch offset from decoder
StallReq  in  1  datapath multi-cycle stall; hold PC this cycle
Start  out  1  to PC stage: load Start_Addr
Halt  out  1  to PC stage: hold PC
Branch  out  1  to PC stage: unconditional branch taken
BranchCond  out  1  to PC stage: conditional branch taken
Offset  out  PC_W  to PC stage: signed offset
Start_Addr  out  PC_W  to PC stage: registered launch address
Running  out  1  high in LOAD and RUN
Done  out  1  one-cycle pulse on entry to HALTED
InstCount  out  CNT_W  retired instructions since last launch
Timeout  out  1  watchdog fired (feature only; else tied 0)

Behaviour:
- Reset (sync, active-high, priority over all):
  - state=IDLE, Start_Addr=0, InstCount=0, Done=0, Timeout=0, watchdog count=0.
  - Combinational outputs: Halt=1, Start=0, Branch=0, BranchCond=0, Offset=0, Running=0.
- Reset asserted mid-RUN: IDLE at next edge; in-flight branch/halt discarded.
- IDLE: Halt=1. If Req, then Start_Addr<=ReqAddr, InstCount<=0, go LOAD.
- LOAD (exactly 1 cycle): Start=1, Halt=0, Running=1. PC loads at this edge; next state RUN.
- RUN: Running=1. Outputs are combinational from decode inputs, zero added latency. Priority order:
  - StallReq: Halt=1, Branch=BranchCond=0, Offset=0. No retire, state held.
  - else DecHalt: Halt=1, go HALTED, no retire.
  - else Halt=0 and:
    - Branch=DecBranch.
    - BranchCond=DecBranchCond&CondFlag&~DecBranch. If both branch flags are set, it is treated as a single unconditional branch; offset is applied once.
    - Offset=DecOffset if Branch|BranchCond, else 0.
    - InstCount+=1, saturating at all-ones.
- Untaken conditional branch: Branch=BranchCond=0, so PC increments; it counts as retired.
- HALTED: Halt=1, Running=0.
  - Done=1 only in the first cycle after the transition.
  - InstCount held.
  - Req: Start_Addr<=ReqAddr, InstCount<=0, Timeout<=0, go LOAD (relaunch).
- Req in LOAD/RUN: ignored, no queueing.
- Offset: passed through unmodified; PC arithmetic wraps mod 2^PC_W in the PC stage.
- Start and Halt are never both 1. Branch and BranchCond are never both 1.

Optional Feature:
RUN_WATCHDOG_EN
- Defined:
  - A counter increments on every RUN cycle, stalled or not, and clears on LOAD.
  - When the count reaches MAX_CYCLES-1 in RUN, force HALTED on the next edge regardless of decode inputs. That cycle drives Halt=1.
  - Timeout<=1, sticky until Req accepted or Reset; Done pulses as normal.
- Undefined: no counter logic, Timeout tied 0, MAX_CYCLES ignored.

Decomposition:
- Package run_ctrl_pkg: state enum typedef (IDLE, LOAD, RUN, HALTED) and PC_W/CNT_W default constants.
- No sub-module: FSM, instruction counter and watchdog are small and inline.

Test Plan:
- Reset, then Req=1 with ReqAddr=8'h10 -> LOAD cycle Start=1, Start_Addr=8'h10; next cycle Running=1, Halt=0.
- RUN with DecBranch=1, DecOffset=8'hFC -> Branch=1, Offset=8'hFC same cycle; InstCount+1.
- RUN with DecBranchCond=1, CondFlag=0 -> BranchCond=0, Offset=0, Halt=0; then with CondFlag=1 -> BranchCond=1.
- StallReq=1 together with DecBranch=1 and DecHalt=1 for 3 cycles -> Halt=1, Branch=0, InstCount unchanged, state RUN; drop StallReq -> halt taken, Done pulses 1 cycle later for 1 cycle.
- 5 retiring instructions then DecHalt -> InstCount=5 held in HALTED; Req with ReqAddr=8'h40 -> InstCount=0, LOAD; Reset mid-RUN -> IDLE, Halt=1, Running=0.
- RUN_WATCHDOG_EN, MAX_CYCLES=20, no DecHalt -> HALTED after 20 RUN cycles, Timeout=1, Done pulse; next Req clears Timeout.
